frame_vram_dbuf: RTL and testbench

FRAME_VRAM_DBUF -- requirements
Module: frame_vram_dbuf

---
 rtl/frame_vram_dbuf_if.sv | 31 +++
 rtl/frame_vram_dbuf.sv | 140 ++++++++++++++
 tb/tb_frame_vram_dbuf.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_vram_dbuf_if.sv
// Pixel write, pixel read, clear and swap signals of the double-buffered frame store.
interface frame_vram_dbuf_if #(
    parameter int AW = 17,
    parameter int DW = 8
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_d;
    logic          wr_ready;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_q;
    logic          rd_valid;
    logic          clr_req;
    logic [DW-1:0] clr_color;
    logic          clr_busy;
    logic          swap_req;
    logic          frame_start;
    logic          swap_pending;
    logic          front_sel;

    modport master (
        output wr_en, wr_addr, wr_d, rd_en, rd_addr, clr_req, clr_color, swap_req, frame_start,
        input  wr_ready, rd_q, rd_valid, clr_busy, swap_pending, front_sel
    );

    modport slave (
        input  wr_en, wr_addr, wr_d, rd_en, rd_addr, clr_req, clr_color, swap_req, frame_start,
        output wr_ready, rd_q, rd_valid, clr_busy, swap_pending, front_sel
    );
endinterface

// File: rtl/frame_vram_dbuf.sv
// Double-buffered frame store: the display reads the front array while the
// renderer writes or bulk-clears the back array; swaps land on frame_start.
//
// Clear FSM
//   state | meaning
//   IDLE  | back buffer open to pixel writes
//   CLEAR | filling back buffer with the latched colour, one pixel per cycle
module frame_vram_dbuf #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int DW     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    frame_vram_dbuf_if.slave bus
);
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int AW   = $clog2(NPIX);
    localparam logic [AW:0]   NPIX_W = NPIX[AW:0];
    localparam logic [AW-1:0] LAST   = AW'(NPIX - 1);

    typedef enum logic {IDLE, CLEAR} clr_state_t;

    logic [DW-1:0] mem [2][NPIX];

    clr_state_t    clr_state;
    logic [AW-1:0] cnt;
    logic [DW-1:0] clr_col;
    logic          clr_sel;
    logic          clr_busy;
    logic          rst_ok;
    logic          front_sel;
    logic          swap_pending;
    logic [DW-1:0] rd_q;
    logic          rd_valid;

    logic          wr_in_range;
    logic          rd_in_range;
    logic          swap_apply;
    logic          we;
    logic          we_sel;
    logic [AW-1:0] we_addr;
    logic [DW-1:0] we_data;

    assign wr_in_range = ({1'b0, bus.wr_addr} < NPIX_W);
    assign rd_in_range = ({1'b0, bus.rd_addr} < NPIX_W);
    assign swap_apply  = rst_ok && bus.frame_start && swap_pending && !clr_busy;

    // Single-stage release so the first edge after rst_n rises is a warm-up
    // edge and operations are accepted from the second edge on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_ok <= 1'b0;
        else        rst_ok <= 1'b1;
    end

    // Clear FSM; the target buffer is the back buffer as it will be after
    // this edge, so a swap landing on the start edge cannot redirect it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_state <= IDLE;
            cnt       <= '0;
            clr_col   <= '0;
            clr_sel   <= 1'b1;
            clr_busy  <= 1'b0;
        end else if (rst_ok) begin
            case (clr_state)
                IDLE: begin
                    if (bus.clr_req) begin
                        clr_state <= CLEAR;
                        cnt       <= '0;
                        clr_col   <= bus.clr_color;
                        clr_sel   <= swap_apply ? front_sel : ~front_sel;
                        clr_busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt == LAST) begin
                        clr_state <= IDLE;
                        clr_busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: clr_state <= IDLE;
            endcase
        end
    end

    // Swap request latch and front-buffer toggle on vertical sync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
        end else if (swap_apply) begin
            front_sel    <= ~front_sel;
            swap_pending <= 1'b0;
        end else if (rst_ok && bus.swap_req) begin
            swap_pending <= 1'b1;
        end
    end

    // One shared array write port: the clear owns it while busy, pixel writes otherwise.
    always_comb begin
        we      = 1'b0;
        we_sel  = ~front_sel;
        we_addr = bus.wr_addr;
        we_data = bus.wr_d;
        if (clr_state == CLEAR) begin
            we      = rst_ok;
            we_sel  = clr_sel;
            we_addr = cnt;
            we_data = clr_col;
        end else if (bus.wr_en && wr_in_range) begin
            we = rst_ok;
        end
    end

    // Pixel arrays, intentionally left unreset.
    always_ff @(posedge clk) begin
        if (we) mem[we_sel][we_addr] <= we_data;
    end

    // Front-buffer read with one cycle of latency; rd_q holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q     <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rst_ok && bus.rd_en;
            if (rst_ok && bus.rd_en) rd_q <= rd_in_range ? mem[front_sel][bus.rd_addr] : '0;
        end
    end

    assign bus.wr_ready     = ~clr_busy;
    assign bus.clr_busy     = clr_busy;
    assign bus.rd_q         = rd_q;
    assign bus.rd_valid     = rd_valid;
    assign bus.front_sel    = front_sel;
    assign bus.swap_pending = swap_pending;
endmodule

// File: tb/tb_frame_vram_dbuf.sv
// Bench for frame_vram_dbuf: directed scenarios plus randomized traffic checked
// against a pixel-array model that applies the write/clear/swap rules directly.
module tb_frame_vram_dbuf;
    localparam int W = 4, H = 2, DW = 8, NP = 8, AW = 3;
    // 3x3 instance: address 9 does not fit in the 3-bit address of the 4x2 frame.
    localparam int W2 = 3, H2 = 3, NP2 = 9, AW2 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    frame_vram_dbuf_if #(.AW(AW),  .DW(DW)) bus ();
    frame_vram_dbuf_if #(.AW(AW2), .DW(DW)) bus2 ();

    frame_vram_dbuf #(.WIDTH(W),  .HEIGHT(H),  .DW(DW)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    frame_vram_dbuf #(.WIDTH(W2), .HEIGHT(H2), .DW(DW)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pixel contents (-1 = never written), displayed buffer,
    // pending swap, pixels left to clear, clear colour and clear target.
    int mdl [2][NP];
    int m_front = 0, m_pend = 0, m_left = 0, m_col = 0, m_tgt = 0;
    int exp_rd_q = 0;
    bit exp_rd_valid = 1'b0;

    task automatic drive_idle();
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_d = '0;
        bus.rd_en = 0; bus.rd_addr = '0;
        bus.clr_req = 0; bus.clr_color = '0;
        bus.swap_req = 0; bus.frame_start = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply the current inputs to the model, then clock the DUT.
    task automatic cycle();
        bit busy_before;
        int a;
        busy_before  = (m_left > 0);
        exp_rd_valid = bus.rd_en;
        if (bus.rd_en) begin
            a = int'(bus.rd_addr);
            exp_rd_q = (a < NP) ? mdl[m_front][a] : 0;
        end
        if (busy_before) begin
            mdl[m_tgt][NP - m_left] = m_col;
            m_left--;
        end else if (bus.wr_en && int'(bus.wr_addr) < NP) begin
            mdl[1 - m_front][bus.wr_addr] = int'(bus.wr_d);
        end
        if (bus.frame_start && m_pend == 1 && !busy_before) begin
            m_front = 1 - m_front;
            m_pend  = 0;
        end else if (bus.swap_req) begin
            m_pend = 1;
        end
        if (!busy_before && bus.clr_req) begin
            m_left = NP;
            m_col  = int'(bus.clr_color);
            m_tgt  = 1 - m_front;
        end
        tick();
    endtask

    task automatic test_reset();
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (bus.rd_q !== 8'h00)      begin n_fail++; $display("FAIL reset_rd_q: got %0h expected 0", bus.rd_q); end
        n_tests++; if (bus.rd_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_rd_valid: got %0b expected 0", bus.rd_valid); end
        n_tests++; if (bus.clr_busy !== 1'b0)   begin n_fail++; $display("FAIL reset_clr_busy: got %0b expected 0", bus.clr_busy); end
        n_tests++; if (bus.wr_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_wr_ready: got %0b expected 1", bus.wr_ready); end
        n_tests++; if (bus.swap_pending !== 1'b0) begin n_fail++; $display("FAIL reset_swap_pending: got %0b expected 0", bus.swap_pending); end
        n_tests++; if (bus.front_sel !== 1'b0)  begin n_fail++; $display("FAIL reset_front_sel: got %0b expected 0", bus.front_sel); end
        rst_n = 1'b1;
        bus.rd_en = 1; bus.rd_addr = '0;
        tick();
        n_tests++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL release_edge1_rd_valid: got %0b expected 0", bus.rd_valid); end
        tick();
        n_tests++; if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL release_edge2_rd_valid: got %0b expected 1", bus.rd_valid); end
        drive_idle();
        tick();
        exp_rd_valid = 1'b0;
        exp_rd_q = -1;
    endtask

    task automatic test_write_swap_read();
        bus.wr_en = 1; bus.wr_addr = 3'd3; bus.wr_d = 8'hA5;
        cycle();
        drive_idle(); bus.swap_req = 1;
        cycle();
        n_tests++; if (bus.swap_pending !== 1'b1) begin n_fail++; $display("FAIL wsr_pending: got %0b expected 1", bus.swap_pending); end
        drive_idle(); bus.frame_start = 1;
        cycle();
        n_tests++; if (bus.front_sel !== m_front[0]) begin n_fail++; $display("FAIL wsr_front_sel: got %0b expected %0b", bus.front_sel, m_front[0]); end
        drive_idle(); bus.rd_en = 1; bus.rd_addr = 3'd3;
        cycle();
        drive_idle();
        n_tests++; if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL wsr_rd_valid: got %0b expected 1", bus.rd_valid); end
        n_tests++; if (bus.rd_q !== exp_rd_q[7:0] || exp_rd_q != 'hA5) begin n_fail++; $display("FAIL wsr_rd_q: got %0h expected a5", bus.rd_q); end
    endtask

    task automatic test_clear();
        int busy_cycles = 0;
        int guard = 0;
        bus.clr_req = 1; bus.clr_color = 8'h3C;
        cycle();
        drive_idle();
        while (bus.clr_busy === 1'b1 && guard < 20) begin
            busy_cycles++; guard++;
            n_tests++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL clear_wr_ready_busy: got %0b expected 0", bus.wr_ready); end
            bus.wr_en = 1; bus.wr_addr = AW'(guard % NP); bus.wr_d = 8'hFF;
            cycle();
        end
        drive_idle();
        n_tests++; if (busy_cycles != NP) begin n_fail++; $display("FAIL clear_busy_cycles: got %0d expected %0d", busy_cycles, NP); end
        n_tests++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL clear_wr_ready_after: got %0b expected 1", bus.wr_ready); end
        bus.swap_req = 1; cycle(); drive_idle();
        bus.frame_start = 1; cycle(); drive_idle();
        n_tests++; if (bus.front_sel !== m_front[0]) begin n_fail++; $display("FAIL clear_front_sel: got %0b expected %0b", bus.front_sel, m_front[0]); end
        for (int i = 0; i < NP; i++) begin
            bus.rd_en = 1; bus.rd_addr = AW'(i);
            cycle();
            n_tests++; if (bus.rd_valid !== 1'b1 || bus.rd_q !== exp_rd_q[7:0] || exp_rd_q != 'h3C)
                begin n_fail++; $display("FAIL clear_read[%0d]: got %0h/%0b expected 3c/1", i, bus.rd_q, bus.rd_valid); end
        end
        drive_idle();
    endtask

    task automatic test_swap_during_clear();
        int guard = 0;
        bus.clr_req = 1; bus.clr_color = 8'h11;
        cycle(); drive_idle();
        cycle();
        bus.swap_req = 1; cycle(); drive_idle();
        cycle();
        bus.frame_start = 1; cycle(); drive_idle();
        n_tests++; if (bus.front_sel !== m_front[0]) begin n_fail++; $display("FAIL sdc_front_held: got %0b expected %0b", bus.front_sel, m_front[0]); end
        n_tests++; if (bus.swap_pending !== 1'b1) begin n_fail++; $display("FAIL sdc_pending_held: got %0b expected 1", bus.swap_pending); end
        while (bus.clr_busy === 1'b1 && guard < 20) begin guard++; cycle(); end
        n_tests++; if (guard >= 20) begin n_fail++; $display("FAIL sdc_busy_timeout: got busy after %0d cycles expected idle", guard); end
        bus.frame_start = 1; cycle(); drive_idle();
        n_tests++; if (bus.front_sel !== m_front[0]) begin n_fail++; $display("FAIL sdc_front_toggle: got %0b expected %0b", bus.front_sel, m_front[0]); end
        n_tests++; if (bus.swap_pending !== 1'b0) begin n_fail++; $display("FAIL sdc_pending_clear: got %0b expected 0", bus.swap_pending); end
    endtask

    task automatic test_swap_same_cycle();
        bus.swap_req = 1; bus.frame_start = 1; cycle(); drive_idle();
        n_tests++; if (bus.swap_pending !== 1'b1) begin n_fail++; $display("FAIL same_pending: got %0b expected 1", bus.swap_pending); end
        n_tests++; if (bus.front_sel !== m_front[0]) begin n_fail++; $display("FAIL same_front_held: got %0b expected %0b", bus.front_sel, m_front[0]); end
        cycle();
        bus.frame_start = 1; cycle(); drive_idle();
        n_tests++; if (bus.front_sel !== m_front[0]) begin n_fail++; $display("FAIL same_front_toggle: got %0b expected %0b", bus.front_sel, m_front[0]); end
    endtask

    task automatic test_out_of_range();
        int expv;
        for (int i = 0; i < NP2; i++) begin
            bus2.wr_en = 1; bus2.wr_addr = AW2'(i); bus2.wr_d = 8'(8'h10 + i);
            tick();
        end
        bus2.wr_addr = 4'd9; bus2.wr_d = 8'hEE; tick();
        bus2.wr_en = 0;
        bus2.swap_req = 1; tick(); bus2.swap_req = 0;
        bus2.frame_start = 1; tick(); bus2.frame_start = 0;
        n_tests++; if (bus2.front_sel !== 1'b1) begin n_fail++; $display("FAIL oor_front_sel: got %0b expected 1", bus2.front_sel); end
        for (int i = 0; i <= NP2; i++) begin
            bus2.rd_en = 1; bus2.rd_addr = AW2'(i);
            tick();
            expv = (i < NP2) ? 'h10 + i : 0;
            n_tests++; if (bus2.rd_valid !== 1'b1 || bus2.rd_q !== expv[7:0])
                begin n_fail++; $display("FAIL oor_read[%0d]: got %0h/%0b expected %0h/1", i, bus2.rd_q, bus2.rd_valid, expv[7:0]); end
        end
        bus2.rd_en = 0;
    endtask

    task automatic test_random();
        bus.clr_req = 1; bus.clr_color = 8'($urandom); cycle(); drive_idle();
        repeat (NP) cycle();
        if (m_pend == 0) begin bus.swap_req = 1; cycle(); drive_idle(); end
        bus.frame_start = 1; cycle(); drive_idle();
        bus.clr_req = 1; bus.clr_color = 8'($urandom); cycle(); drive_idle();
        repeat (NP) cycle();
        for (int i = 0; i < 300; i++) begin
            bus.wr_en = 1'($urandom_range(0, 1));
            bus.wr_addr = AW'($urandom_range(0, NP - 1));
            bus.wr_d = 8'($urandom);
            bus.rd_en = 1'($urandom_range(0, 1));
            bus.rd_addr = AW'($urandom_range(0, NP - 1));
            bus.swap_req = ($urandom_range(0, 7) == 0);
            bus.frame_start = ($urandom_range(0, 5) == 0);
            bus.clr_req = ($urandom_range(0, 39) == 0);
            bus.clr_color = 8'($urandom);
            cycle();
            n_tests++; if (bus.rd_valid !== exp_rd_valid) begin n_fail++; $display("FAIL rnd_rd_valid[%0d]: got %0b expected %0b", i, bus.rd_valid, exp_rd_valid); end
            if (exp_rd_q >= 0) begin
                n_tests++; if (bus.rd_q !== exp_rd_q[7:0]) begin n_fail++; $display("FAIL rnd_rd_q[%0d]: got %0h expected %0h", i, bus.rd_q, exp_rd_q[7:0]); end
            end
            n_tests++; if (bus.front_sel !== m_front[0]) begin n_fail++; $display("FAIL rnd_front_sel[%0d]: got %0b expected %0b", i, bus.front_sel, m_front[0]); end
            n_tests++; if (bus.swap_pending !== m_pend[0]) begin n_fail++; $display("FAIL rnd_swap_pending[%0d]: got %0b expected %0b", i, bus.swap_pending, m_pend[0]); end
            n_tests++; if (bus.clr_busy !== (m_left > 0)) begin n_fail++; $display("FAIL rnd_clr_busy[%0d]: got %0b expected %0b", i, bus.clr_busy, (m_left > 0)); end
        end
        drive_idle();
    endtask

    task automatic test_reset_mid_clear();
        repeat (NP + 1) cycle();
        if (m_pend == 1) begin bus.frame_start = 1; cycle(); drive_idle(); end
        if (m_front == 0) begin
            bus.swap_req = 1; cycle(); drive_idle();
            bus.frame_start = 1; cycle(); drive_idle();
        end
        for (int i = 0; i < NP; i++) begin
            bus.wr_en = 1; bus.wr_addr = AW'(i); bus.wr_d = 8'(8'h80 + i);
            cycle();
        end
        drive_idle();
        bus.clr_req = 1; bus.clr_color = 8'h5A; cycle(); drive_idle();
        repeat (3) cycle();
        rst_n = 1'b0;
        m_front = 0; m_pend = 0; m_left = 0; exp_rd_q = 0; exp_rd_valid = 1'b0;
        #1;
        n_tests++; if (bus.clr_busy !== 1'b0)  begin n_fail++; $display("FAIL rmc_clr_busy: got %0b expected 0", bus.clr_busy); end
        n_tests++; if (bus.front_sel !== 1'b0) begin n_fail++; $display("FAIL rmc_front_sel: got %0b expected 0", bus.front_sel); end
        n_tests++; if (bus.wr_ready !== 1'b1)  begin n_fail++; $display("FAIL rmc_wr_ready: got %0b expected 1", bus.wr_ready); end
        repeat (2) tick();
        rst_n = 1'b1;
        cycle();
        for (int i = 0; i < NP; i++) begin
            bus.rd_en = 1; bus.rd_addr = AW'(i);
            cycle();
            n_tests++; if (bus.rd_valid !== 1'b1 || bus.rd_q !== exp_rd_q[7:0] || exp_rd_q != ((i < 3) ? 'h5A : 'h80 + i))
                begin n_fail++; $display("FAIL rmc_read[%0d]: got %0h/%0b expected %0h/1", i, bus.rd_q, bus.rd_valid, exp_rd_q[7:0]); end
        end
        drive_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int b = 0; b < 2; b++)
            for (int p = 0; p < NP; p++) mdl[b][p] = -1;
        drive_idle();
        bus2.wr_en = 0; bus2.wr_addr = '0; bus2.wr_d = '0;
        bus2.rd_en = 0; bus2.rd_addr = '0;
        bus2.clr_req = 0; bus2.clr_color = '0;
        bus2.swap_req = 0; bus2.frame_start = 0;
        test_reset();
        test_write_swap_read();
        test_clear();
        test_swap_during_clear();
        test_swap_same_cycle();
        test_out_of_range();
        test_random();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
